// File: rtl/ql_bank_config_loader.sv
// Streams bitstream words into a BL_WIDTH-bit bit-line row, then strobes one word line per row
// so each frame is shifted into a memory-bank tile's bl_in/wl_in configuration chain.
module ql_bank_config_loader #(
    parameter int BL_WIDTH  = 315,
    parameter int WL_WIDTH  = 4,
    parameter int DIN_WIDTH = 32,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                 prog_clk,
    input  logic                 prog_reset_n,
    input  logic                 start,
    input  logic [DIN_WIDTH-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [BL_WIDTH-1:0]  bl_out,
    output logic [WL_WIDTH-1:0]  wl_out,
    output logic                 busy,
    output logic                 done
);

    localparam int WPR     = (BL_WIDTH + DIN_WIDTH - 1) / DIN_WIDTH;
    localparam int WORD_W  = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int ROW_W   = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t              state_reg;
    logic [ROW_W-1:0]    row_reg;
    logic [WORD_W-1:0]   word_reg;
    logic [TMR_W-1:0]    tmr_reg;
    logic [BL_WIDTH-1:0] bl_reg;
    logic [BL_WIDTH-1:0] bl_next;
    logic [WL_WIDTH-1:0] wl_reg;
    logic                din_ready_reg;
    logic                busy_reg;
    logic                done_reg;

    logic xfer;
    logic last_word;
    logic last_row;
    logic tmr_zero;

    assign xfer      = din_valid & din_ready_reg;
    assign last_word = (word_reg == WORD_W'(WPR - 1));
    assign last_row  = (row_reg == ROW_W'(WL_WIDTH - 1));
    assign tmr_zero  = (tmr_reg == '0);

    // Each slice takes din only when its word index is being transferred; the last
    // slice is narrower, so the surplus high bits of that word simply have no home.
    for (genvar gi = 0; gi < WPR; gi++) begin : g_slice
        localparam int LO = gi * DIN_WIDTH;
        localparam int SW = ((BL_WIDTH - LO) < DIN_WIDTH) ? (BL_WIDTH - LO) : DIN_WIDTH;
        assign bl_next[LO +: SW] = (xfer && (word_reg == WORD_W'(gi))) ? din[SW-1:0]
                                                                       : bl_reg[LO +: SW];
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_reg     <= S_IDLE;
            row_reg       <= '0;
            word_reg      <= '0;
            tmr_reg       <= '0;
            bl_reg        <= '0;
            wl_reg        <= '0;
            din_ready_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg     <= S_LOAD;
                        row_reg       <= '0;
                        word_reg      <= '0;
                        busy_reg      <= 1'b1;
                        din_ready_reg <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        bl_reg <= bl_next;
                        if (last_word) begin
                            word_reg      <= '0;
                            din_ready_reg <= 1'b0;
                            tmr_reg       <= TMR_W'(SETUP_CYC - 1);
                            state_reg     <= S_SETUP;
                        end else begin
                            word_reg <= word_reg + 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    if (tmr_zero) begin
                        wl_reg    <= WL_WIDTH'(1) << row_reg;
                        tmr_reg   <= TMR_W'(PULSE_CYC - 1);
                        state_reg <= S_PULSE;
                    end else begin
                        tmr_reg <= tmr_reg - 1'b1;
                    end
                end
                S_PULSE: begin
                    if (tmr_zero) begin
                        wl_reg    <= '0;
                        tmr_reg   <= TMR_W'(HOLD_CYC - 1);
                        state_reg <= S_HOLD;
                    end else begin
                        tmr_reg <= tmr_reg - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!tmr_zero) begin
                        tmr_reg <= tmr_reg - 1'b1;
                    end else if (last_row) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        row_reg       <= row_reg + 1'b1;
                        din_ready_reg <= 1'b1;
                        state_reg     <= S_LOAD;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign din_ready = din_ready_reg;
    assign bl_out    = bl_reg;
    assign wl_out    = wl_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_ql_bank_config_loader.sv
// Directed bench for ql_bank_config_loader: rows are modelled as they are streamed in and
// compared when their word-line strobe appears; a negedge monitor checks per-cycle rules.
module tb_ql_bank_config_loader;

    localparam int BLW = 315;
    localparam int WLW = 4;
    localparam int DW  = 32;
    localparam int WPR = 10;

    logic           prog_clk = 1'b0;
    logic           prog_reset_n;
    logic           start;
    logic [DW-1:0]  din;
    logic           din_valid;
    logic           din_ready;
    logic [BLW-1:0] bl_out;
    logic [WLW-1:0] wl_out;
    logic           busy;
    logic           done;

    ql_bank_config_loader dut (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .start        (start),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .bl_out       (bl_out),
        .wl_out       (wl_out),
        .busy         (busy),
        .done         (done)
    );

    always #5 prog_clk = ~prog_clk;

    typedef struct packed {
        logic [BLW-1:0] bl;
        logic [WLW-1:0] wl;
    } exp_t;

    exp_t           exp_q[$];
    exp_t           mon_e;
    logic [BLW-1:0] bl_model;
    int             errors = 0;
    int             checks = 0;
    int             cyc = 0;

    always @(posedge prog_clk) cyc++;

    task automatic chk(input string tag, input logic [BLW-1:0] obs, input logic [BLW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle monitor: row scoreboard, strobe timing, and structural rules.
    int             words_seen = 0;
    int             stalls = 0;
    int             first_xfer = 0;
    int             last_xfer = 0;
    int             hi_len = 0;
    logic [WLW-1:0] prev_wl = '0;
    logic [BLW-1:0] prev_bl = '0;

    always @(negedge prog_clk) begin
        if (!prog_reset_n) begin
            words_seen = 0;
            stalls     = 0;
            hi_len     = 0;
            prev_wl    = '0;
        end else begin
            chk("wl_onehot0", BLW'($onehot0(wl_out)), BLW'(1));
            if (wl_out != 0 || !busy)
                chk("ready_outside_load", BLW'(din_ready), BLW'(0));
            if (wl_out != 0 && prev_wl != 0)
                chk("bl_stable_in_pulse", bl_out, prev_bl);
            if (wl_out != 0 && prev_wl == 0) begin
                chk("row_expected", BLW'(exp_q.size() > 0), BLW'(1));
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("row_wl", BLW'(wl_out), BLW'(mon_e.wl));
                    chk("row_bl", bl_out, mon_e.bl);
                end
                // last word cycle, one SETUP cycle, then the strobe
                chk("setup_gap", BLW'(cyc - last_xfer), BLW'(2));
            end
            if (wl_out != 0) begin
                hi_len++;
            end else if (prev_wl != 0) begin
                chk("pulse_len", BLW'(hi_len), BLW'(2));
                hi_len = 0;
            end
            if (din_ready && !din_valid && words_seen > 0) stalls++;
            if (din_valid && din_ready) begin
                if (words_seen == 0) first_xfer = cyc;
                last_xfer = cyc;
                words_seen++;
            end
            if (done) begin
                // word 0 accepted in cycle 0, done high in cycle 56 plus any stalls
                chk("done_latency", BLW'(cyc - first_xfer), BLW'(56 + stalls));
                chk("done_words", BLW'(words_seen), BLW'(40));
                chk("done_busy_low", BLW'(busy), BLW'(0));
                words_seen = 0;
                stalls     = 0;
            end
            prev_wl = wl_out;
            prev_bl = bl_out;
        end
    end

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] w, input bit gap);
        int n;
        if (gap) begin
            din       = 32'hDEAD_BEEF;
            din_valid = 1'b0;
            tick();
            chk("ready_held_in_gap", BLW'(din_ready), BLW'(1));
            chk("wl_low_in_load", BLW'(wl_out), BLW'(0));
        end
        din       = w;
        din_valid = 1'b1;
        n = 0;
        while (!din_ready && n < 100) begin
            tick();
            n++;
        end
        chk("ready_timeout", BLW'(din_ready), BLW'(1));
        tick();
        din_valid = 1'b0;
    endtask

    task automatic send_row(input int r, input logic [DW-1:0] base, input bit gap, input bit ones);
        logic [DW-1:0] w;
        exp_t          e;
        for (int k = 0; k < WPR; k++) begin
            w = (ones && k == WPR - 1) ? 32'hFFFF_FFFF : base + DW'(k);
            for (int b = 0; b < DW; b++)
                if (k * DW + b < BLW) bl_model[k * DW + b] = w[b];
            send_word(w, gap && k > 0);
        end
        e.bl = bl_model;
        e.wl = 4'b0001 << r;
        exp_q.push_back(e);
    endtask

    task automatic wait_wl(input logic [WLW-1:0] pattern);
        int n = 0;
        while (wl_out == 0 && n < 100) begin
            tick();
            n++;
        end
        chk("wl_first_strobe", BLW'(wl_out), BLW'(pattern));
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        chk("done_seen", BLW'(done), BLW'(1));
    endtask

    initial begin
        prog_reset_n = 1'b0;
        start        = 1'b0;
        din          = '0;
        din_valid    = 1'b0;
        bl_model     = '0;
        repeat (3) tick();
        chk("rst_bl", bl_out, '0);
        chk("rst_wl", BLW'(wl_out), BLW'(0));
        chk("rst_ready", BLW'(din_ready), BLW'(0));
        chk("rst_busy", BLW'(busy), BLW'(0));
        chk("rst_done", BLW'(done), BLW'(0));
        prog_reset_n = 1'b1;
        tick();
        chk("idle_ready", BLW'(din_ready), BLW'(0));

        // T1: plain back-to-back load, words 0..9 = A5A5_0000+k
        do_start();
        chk("busy_after_start", BLW'(busy), BLW'(1));
        send_row(0, 32'hA5A5_0000, 1'b0, 1'b0);
        wait_wl(4'b0001);
        chk("t1_bl_word0", BLW'(bl_out[31:0]), BLW'(32'hA5A5_0000));
        for (int r = 1; r < WLW; r++) send_row(r, 32'hA5A5_0000 + DW'(r * 10), 1'b0, 1'b0);
        wait_done();
        tick();

        // T4 + T2: start during a pulse and in the done cycle; all-ones last word on row 2
        do_start();
        send_row(0, 32'h1234_0000, 1'b0, 1'b0);
        send_row(1, 32'h1234_0100, 1'b0, 1'b0);
        wait_wl(4'b0010);
        do_start();
        chk("t4_busy_mid", BLW'(busy), BLW'(1));
        send_row(2, 32'h1234_0200, 1'b0, 1'b1);
        wait_wl(4'b0100);
        chk("t2_bl_top", BLW'(bl_out[314:288]), BLW'(27'h7FF_FFFF));
        send_row(3, 32'h1234_0300, 1'b0, 1'b0);
        wait_done();
        do_start();
        chk("t4_done_start_ready", BLW'(din_ready), BLW'(0));
        chk("t4_done_start_busy", BLW'(busy), BLW'(0));
        tick();
        chk("t4_still_idle", BLW'(din_ready), BLW'(0));

        // T5: asynchronous reset in the middle of row 2's pulse
        do_start();
        for (int r = 0; r < 3; r++) send_row(r, 32'h0F0F_0000 + DW'(r * 16), 1'b0, 1'b0);
        wait_wl(4'b0100);
        #1;
        prog_reset_n = 1'b0;
        #1;
        chk("t5_wl_async", BLW'(wl_out), BLW'(0));
        chk("t5_busy", BLW'(busy), BLW'(0));
        chk("t5_ready", BLW'(din_ready), BLW'(0));
        chk("t5_bl", bl_out, '0);
        exp_q.delete();
        bl_model = '0;
        repeat (2) tick();
        prog_reset_n = 1'b1;
        tick();

        // T3 after reset: din_valid toggles between words; first strobe must be row 0
        do_start();
        send_row(0, 32'h5A5A_1000, 1'b1, 1'b0);
        wait_wl(4'b0001);
        for (int r = 1; r < WLW; r++) send_row(r, 32'h5A5A_1000 + DW'(r * 10), 1'b1, 1'b0);
        wait_done();
        tick();
        chk("queue_drained", BLW'(exp_q.size()), BLW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
